// File: rtl/rf_ctrl.sv
// rf_ctrl: sequencer that runs MOVI/MOV/ADD/CMP commands against an
// external register file with one read port and one write port.
module rf_ctrl #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [2:0]        rd,
    input  logic [2:0]        rn,
    input  logic [2:0]        rm,
    input  logic [7:0]        imm8,
    output logic              busy,
    output logic              done,
    output logic              z,
    output logic              n,
    output logic [2:0]        rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data,
    output logic              rf_w_en,
    output logic [2:0]        rf_r_addr,
    input  logic [DATA_W-1:0] rf_r_data
);

    localparam logic [1:0] OP_MOVI = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_CMP  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_WB,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [1:0]        op_q;
    logic [2:0]        rd_q, rn_q, rm_q;
    logic [7:0]        imm8_q;
    logic [DATA_W-1:0] a_q, b_q, res_q;
    logic              z_q, n_q;

    logic              accept;
    logic [DATA_W-1:0] rdb_res;
    logic              upd_flags;

    assign accept    = (state_q == S_IDLE) && start;
    assign upd_flags = (op_q == OP_ADD) || (op_q == OP_CMP);

    // Result of the op as it stands on the RD_B exit edge
    always_comb begin
        rdb_res = rf_r_data;
        unique case (op_q)
            OP_ADD:  rdb_res = a_q + rf_r_data;
            OP_CMP:  rdb_res = a_q - rf_r_data;
            default: rdb_res = rf_r_data;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: each op takes its own path back to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    unique case (op)
                        OP_MOVI: state_d = S_WB;
                        OP_MOV:  state_d = S_RD_B;
                        default: state_d = S_RD_A;
                    endcase
                end
            end
            S_RD_A:  state_d = S_RD_B;
            S_RD_B:  state_d = (op_q == OP_CMP) ? S_DONE : S_WB;
            S_WB:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_DONE);
        rf_w_en   = (state_q == S_WB) && !rst;
        rf_r_addr = 3'd0;
        unique case (state_q)
            S_RD_A:  rf_r_addr = rn_q;
            S_RD_B:  rf_r_addr = rm_q;
            default: rf_r_addr = 3'd0;
        endcase
    end

    // Command capture, operand loads, result and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            rd_q   <= '0;
            rn_q   <= '0;
            rm_q   <= '0;
            imm8_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
            res_q  <= '0;
            z_q    <= 1'b0;
            n_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= op;
                rd_q   <= rd;
                rn_q   <= rn;
                rm_q   <= rm;
                imm8_q <= imm8;
                if (op == OP_MOVI)
                    res_q <= {{(DATA_W-8){imm8[7]}}, imm8};
            end
            if (state_q == S_RD_A)
                a_q <= rf_r_data;
            if (state_q == S_RD_B) begin
                b_q   <= rf_r_data;
                res_q <= rdb_res;
                if (upd_flags) begin
                    z_q <= (rdb_res == '0);
                    n_q <= rdb_res[DATA_W-1];
                end
            end
        end
    end

    assign rf_w_addr = rd_q;
    assign rf_w_data = res_q;
    assign z         = z_q;
    assign n         = n_q;

endmodule

// File: tb/tb_rf_ctrl.sv
// tb_rf_ctrl: directed bench for rf_ctrl with a behavioural 8x16
// register file hung on its read/write ports.
module tb_rf_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [2:0]  rd, rn, rm;
    logic [7:0]  imm8;
    logic        busy, done, z, n;
    logic [2:0]  rf_w_addr, rf_r_addr;
    logic [15:0] rf_w_data, rf_r_data;
    logic        rf_w_en;

    logic [15:0] rf [8];
    logic        tb_we = 1'b0;
    logic [2:0]  tb_wa = '0;
    logic [15:0] tb_wd = '0;
    int          wr_cnt = 0;
    int          r0_wr = 0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rf_ctrl #(.DATA_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rd        (rd),
        .rn        (rn),
        .rm        (rm),
        .imm8      (imm8),
        .busy      (busy),
        .done      (done),
        .z         (z),
        .n         (n),
        .rf_w_addr (rf_w_addr),
        .rf_w_data (rf_w_data),
        .rf_w_en   (rf_w_en),
        .rf_r_addr (rf_r_addr),
        .rf_r_data (rf_r_data)
    );

    assign rf_r_data = rf[rf_r_addr];

    always @(posedge clk) begin
        if (rf_w_en) begin
            rf[rf_w_addr] <= rf_w_data;
            wr_cnt <= wr_cnt + 1;
            if (rf_w_addr == 3'd0) r0_wr <= r0_wr + 1;
        end else if (tb_we) begin
            rf[tb_wa] <= tb_wd;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [15:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic exec(input logic [1:0] o, input logic [2:0] d,
                        input logic [2:0] s, input logic [2:0] m,
                        input logic [7:0] im,
                        output int lat, output int wc,
                        output int ra0, output int ra1,
                        output int wa, output int wd);
        op = o; rd = d; rn = s; rm = m; imm8 = im;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0; wc = 0; ra0 = -1; ra1 = -1; wa = -1; wd = -1;
        for (int i = 1; i <= 10; i++) begin
            if (i == 1) ra0 = int'(rf_r_addr);
            if (i == 2) ra1 = int'(rf_r_addr);
            if (rf_w_en) begin
                wc++;
                wa = int'(rf_w_addr);
                wd = int'(rf_w_data);
            end
            if (done) begin
                lat = i;
                break;
            end
            tick();
        end
        tick();
    endtask

    int lat, wc, ra0, ra1, wa, wd, snap;

    initial begin
        rst = 1'b1; start = 1'b0; op = '0;
        rd = '0; rn = '0; rm = '0; imm8 = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_z", z, 0);
        chk("rst_n", n, 0);
        chk("rst_raddr", rf_r_addr, 0);
        chk("rst_wdata", rf_w_data, 0);
        chk("rst_waddr", rf_w_addr, 0);
        chk("rst_wen", rf_w_en, 0);

        preload(3'd1, 16'd9);
        preload(3'd2, 16'd7);
        preload(3'd5, 16'd3);
        preload(3'd6, 16'd5);
        preload(3'd7, 16'h1234);

        // ADD R3 = R1 + R2 = 16
        exec(2'b10, 3'd3, 3'd1, 3'd2, 8'h00, lat, wc, ra0, ra1, wa, wd);
        chk("add_lat", lat, 4);
        chk("add_ra0", ra0, 1);
        chk("add_ra1", ra1, 2);
        chk("add_wcnt", wc, 1);
        chk("add_waddr", wa, 3);
        chk("add_wdata", wd, 16);
        chk("add_z", z, 0);
        chk("add_n", n, 0);
        chk("add_idle", busy, 0);
        chk("add_done_pulse", done, 0);
        chk("add_rf3", rf[3], 16'd16);

        // CMP R5 - R6 = 3 - 5 -> FFFE, never written
        exec(2'b11, 3'd4, 3'd5, 3'd6, 8'h00, lat, wc, ra0, ra1, wa, wd);
        chk("cmp_lat", lat, 3);
        chk("cmp_ra0", ra0, 5);
        chk("cmp_ra1", ra1, 6);
        chk("cmp_wcnt", wc, 0);
        chk("cmp_z", z, 0);
        chk("cmp_n", n, 1);
        chk("cmp_res", rf_w_data, 16'hFFFE);

        // ADD wraps: 8000 + 8000 = 0
        preload(3'd1, 16'h8000);
        preload(3'd2, 16'h8000);
        exec(2'b10, 3'd4, 3'd1, 3'd2, 8'h00, lat, wc, ra0, ra1, wa, wd);
        chk("ovf_lat", lat, 4);
        chk("ovf_waddr", wa, 4);
        chk("ovf_wdata", wd, 0);
        chk("ovf_z", z, 1);
        chk("ovf_n", n, 0);
        chk("ovf_rf4", rf[4], 16'h0000);

        // MOVI R2 = sext(F6); flags stay z=1 n=0
        exec(2'b00, 3'd2, 3'd0, 3'd0, 8'hF6, lat, wc, ra0, ra1, wa, wd);
        chk("movi_lat", lat, 2);
        chk("movi_wcnt", wc, 1);
        chk("movi_waddr", wa, 2);
        chk("movi_wdata", wd, 16'hFFF6);
        chk("movi_z", z, 1);
        chk("movi_n", n, 0);
        chk("movi_rf2", rf[2], 16'hFFF6);

        // MOV R0 = R7 with start held; next cmd MOVI R6 = 5
        op = 2'b01; rd = 3'd0; rn = 3'd0; rm = 3'd7; imm8 = 8'h00;
        start = 1'b1;
        tick();
        chk("mov_rdb_busy", busy, 1);
        chk("mov_rdb_raddr", rf_r_addr, 7);
        tick();
        chk("mov_wb_wen", rf_w_en, 1);
        chk("mov_wb_waddr", rf_w_addr, 0);
        chk("mov_wb_wdata", rf_w_data, 16'h1234);
        tick();
        chk("mov_done", done, 1);
        op = 2'b00; rd = 3'd6; imm8 = 8'h05;
        tick();
        chk("mov_idle_busy", busy, 0);
        chk("mov_idle_done", done, 0);
        tick();
        chk("held_wen", rf_w_en, 1);
        chk("held_waddr", rf_w_addr, 6);
        chk("held_wdata", rf_w_data, 16'h0005);
        start = 1'b0;
        tick();
        chk("held_done", done, 1);
        tick();
        chk("held_idle", busy, 0);
        chk("mov_r0_writes", r0_wr, 1);
        chk("mov_rf0", rf[0], 16'h1234);
        chk("held_rf6", rf[6], 16'h0005);
        chk("mov_z", z, 1);
        chk("mov_n", n, 0);

        // ADD R3 = R3 + R3 = 32
        exec(2'b10, 3'd3, 3'd3, 3'd3, 8'h00, lat, wc, ra0, ra1, wa, wd);
        chk("dbl_lat", lat, 4);
        chk("dbl_ra0", ra0, 3);
        chk("dbl_ra1", ra1, 3);
        chk("dbl_wdata", wd, 32);
        chk("dbl_rf3", rf[3], 16'd32);
        chk("dbl_z", z, 0);

        // ADD R5 = R5 + R1 (8003), reset while in WB
        op = 2'b10; rd = 3'd5; rn = 3'd5; rm = 3'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rwb_ra0", rf_r_addr, 5);
        tick();
        chk("rwb_ra1", rf_r_addr, 1);
        tick();
        chk("rwb_wen_pre", rf_w_en, 1);
        chk("rwb_n_pre", n, 1);
        rst = 1'b1;
        start = 1'b1;
        #1;
        chk("rwb_wen_rst", rf_w_en, 0);
        snap = wr_cnt;
        tick();
        chk("rwb_busy", busy, 0);
        chk("rwb_done", done, 0);
        chk("rwb_z", z, 0);
        chk("rwb_n", n, 0);
        chk("rwb_wdata", rf_w_data, 0);
        chk("rwb_waddr", rf_w_addr, 0);
        chk("rwb_raddr", rf_r_addr, 0);
        chk("rwb_nowrite", wr_cnt, snap);
        chk("rwb_rf5", rf[5], 16'd3);
        tick();
        chk("rst_start_ign", busy, 0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        chk("post_rst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
